arc_byte_framer: RTL
====================

ARC_BYTE_FRAMER -- requirements
Module: arc_byte_framer

Interface
REQ-001 SHALL have these ports, clock and reset first: clk  in  1  single clock, rising-edge.
REQ-002 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ena  in  1  design enable; when low, pin edges are ignored and state holds.
REQ-004 SHALL have byte_in  in  8  pin data byte, held stable by the host while byte_stb is high.
REQ-005 SHALL have byte_stb  in  1  raw asynchronous pin strobe; its rising edge means a new byte.
REQ-006 SHALL have word_out  out  32  assembled word to the crypto core.
REQ-007 SHALL have word_valid  out  1  and word_ready  in  1  as the word handshake.
REQ-008 SHALL have res_in  in  32  result word from the crypto core.
REQ-009 SHALL have res_valid  in  1  and res_ready  out  1  as the result handshake.
REQ-010 SHALL have byte_out  out  8  result byte to the pins.
REQ-011 SHALL have byte_out_vld  out  1  result byte present.
REQ-012 SHALL have byte_ack  in  1  raw asynchronous pin acknowledge; its rising edge means the byte was consumed.
REQ-013 SHALL have err  out  1  sticky error flag.

Function
REQ-014 SHALL pass byte_stb and byte_ack each through a 2-flop synchronizer plus one edge register; an edge is detected on the 3rd rising clk after the pin rises.
REQ-015 SHALL run the input FSM in states ASM (count 0..3) and HOLD.
REQ-016 SHALL capture byte_in little-endian in ASM: byte k goes to word_out[8k+7:8k].
REQ-017 SHALL, at the edge capturing byte 3, set word_valid=1 and enter HOLD.
REQ-018 SHALL, on word_valid and word_ready both high, clear word_valid at the next edge and return to ASM with count=0.
REQ-019 SHALL, for a strobe edge in HOLD without a handshake in the same cycle, drop the byte, set err and leave word_out unchanged.
REQ-020 SHALL, for a strobe edge in the same cycle as the word handshake, capture the byte as byte 0 of the next word (count=1).
REQ-021 SHALL run the output FSM in states IDLE and SEND; res_ready=1 only in IDLE.
REQ-022 SHALL, on res_valid and res_ready both high, latch res_in, enter SEND and drive byte_out=res[7:0] with byte_out_vld=1 at that edge.
REQ-023 SHALL, in SEND, advance byte_out to the next byte (little-endian) on each ack edge; the 4th ack edge returns to IDLE with byte_out_vld=0.
REQ-024 SHALL ignore ack edges while in IDLE.
REQ-025 SHALL, with ena=0, ignore detected edges (no capture, no err) while the synchronizers keep running and the handshakes on the core side still complete.
REQ-026 SHALL keep err high from first error until reset.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear word_out, word_valid, byte_out, byte_out_vld, err, count, all synchronizers and the latched result, and force both FSMs to ASM/IDLE (res_ready=1).
REQ-028 SHALL, on reset assertion mid-word or mid-send, discard partial data; the first strobe edge after release is byte 0.

Configuration
REQ-029 SHALL, when ARC_CHECKSUM_EN is defined, expect a 5th byte equal to the XOR of bytes 0..3: on a match, set word_valid at the 5th capture; on a mismatch, discard the word, set err and return to ASM with count=0.
REQ-030 SHALL, when ARC_CHECKSUM_EN is undefined, frame exactly 4 bytes per word with no checksum logic.

Verification
REQ-031 Bytes 0x11,0x22,0x33,0x44 with word_ready=1 -> word_out=0x44332211, word_valid high for 1 cycle, err=0.
REQ-032 word_ready=0 after a full word plus one extra strobe -> err=1, word_out still 0x44332211; then word_ready=1 -> word_valid falls, err stays 1.
REQ-033 res_in=0xDEADBEEF with res_valid pulse and 4 ack edges -> byte_out EF,BE,AD,DE in order; byte_out_vld=0 and res_ready=1 after the 4th ack.
REQ-034 rst_n pulsed low after 2 bytes, then 4 bytes AA,BB,CC,DD sent -> word_out=0xDDCCBBAA.
REQ-035 With ARC_CHECKSUM_EN: 01,02,04,08,0F -> word 0x08040201 valid; 01,02,04,08,00 -> no word_valid, err=1.
REQ-036 ena=0 while 4 strobes are sent -> no word_valid, err=0, count unchanged.

Source files
------------

// File: rtl/arc_byte_framer.sv
// Pin-side byte framer: assembles strobed bytes into 32-bit words and serialises result words back out.
// Optional ARC_CHECKSUM_EN adds a 5th XOR checksum byte per word.
module arc_byte_framer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  byte_in,
  input  logic        byte_stb,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  input  logic [31:0] res_in,
  input  logic        res_valid,
  output logic        res_ready,
  output logic [7:0]  byte_out,
  output logic        byte_out_vld,
  input  logic        byte_ack,
  output logic        err
);

`ifdef ARC_CHECKSUM_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif

  typedef enum logic {ASM, HOLD} in_st_e;
  typedef enum logic {IDLE, SEND} out_st_e;

  // [0],[1] synchronise the pin; [2] holds the previous synchronised level
  logic [2:0] stb_sync_q, ack_sync_q;
  logic       stb_evt, ack_evt;

  in_st_e        in_st_q, in_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;
  logic          wv_q, wv_d;
  logic          err_q, err_d;

  out_st_e     out_st_q, out_st_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  idx_q, idx_d, nxt_idx;
  logic [7:0]  bo_q, bo_d;
  logic        bov_q, bov_d;

  assign stb_evt = ena & stb_sync_q[1] & ~stb_sync_q[2];
  assign ack_evt = ena & ack_sync_q[1] & ~ack_sync_q[2];

`ifdef ARC_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = word_q[7:0] ^ word_q[15:8] ^ word_q[23:16] ^ word_q[31:24];
`endif

  always_comb begin
    in_st_d  = in_st_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    wv_d     = wv_q;
    err_d    = err_q;
    out_st_d = out_st_q;
    res_d    = res_q;
    idx_d    = idx_q;
    bo_d     = bo_q;
    bov_d    = bov_q;
    nxt_idx  = idx_q + 2'd1;

    case (in_st_q)
      ASM: begin
        if (stb_evt) begin
`ifdef ARC_CHECKSUM_EN
          if (cnt_q == 3'd4) begin
            cnt_d = '0;
            if (byte_in == csum) begin
              wv_d    = 1'b1;
              in_st_d = HOLD;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
            cnt_d = cnt_q + 1'b1;
          end
`else
          word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
          if (cnt_q == 2'd3) begin
            cnt_d   = '0;
            wv_d    = 1'b1;
            in_st_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        if (wv_q && word_ready) begin
          wv_d    = 1'b0;
          in_st_d = ASM;
          cnt_d   = '0;
          // a byte arriving alongside the handshake starts the next word
          if (stb_evt) begin
            word_d[7:0] = byte_in;
            cnt_d       = CW'(1);
          end
        end else if (stb_evt) begin
          err_d = 1'b1;
        end
      end
      default: in_st_d = ASM;
    endcase

    case (out_st_q)
      IDLE: begin
        if (res_valid) begin
          res_d    = res_in;
          bo_d     = res_in[7:0];
          bov_d    = 1'b1;
          idx_d    = 2'd0;
          out_st_d = SEND;
        end
      end
      SEND: begin
        if (ack_evt) begin
          if (idx_q == 2'd3) begin
            bov_d    = 1'b0;
            idx_d    = 2'd0;
            out_st_d = IDLE;
          end else begin
            idx_d = nxt_idx;
            bo_d  = res_q[{nxt_idx, 3'b000} +: 8];
          end
        end
      end
      default: out_st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_sync_q <= '0;
      ack_sync_q <= '0;
      in_st_q    <= ASM;
      cnt_q      <= '0;
      word_q     <= '0;
      wv_q       <= 1'b0;
      err_q      <= 1'b0;
      out_st_q   <= IDLE;
      res_q      <= '0;
      idx_q      <= '0;
      bo_q       <= '0;
      bov_q      <= 1'b0;
    end else begin
      stb_sync_q <= {stb_sync_q[1:0], byte_stb};
      ack_sync_q <= {ack_sync_q[1:0], byte_ack};
      in_st_q    <= in_st_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wv_q       <= wv_d;
      err_q      <= err_d;
      out_st_q   <= out_st_d;
      res_q      <= res_d;
      idx_q      <= idx_d;
      bo_q       <= bo_d;
      bov_q      <= bov_d;
    end
  end

  assign word_out     = word_q;
  assign word_valid   = wv_q;
  assign res_ready    = (out_st_q == IDLE);
  assign byte_out     = bo_q;
  assign byte_out_vld = bov_q;
  assign err          = err_q;

endmodule
